// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS/CTRL bit positions and the transmit FSM state encoding.
// Optional even-parity bit is selected with `UART_TX_PARITY_EN.
package mmio_uart_pkg;

  // Register offsets within the 16-byte window (addr[3:0])
  localparam logic [3:0] TXDATA_OFF = 4'h0;
  localparam logic [3:0] STATUS_OFF = 4'h4;
  localparam logic [3:0] CTRL_OFF   = 4'h8;

  // STATUS bit positions
  localparam int unsigned ST_BUSY_BIT  = 0;
  localparam int unsigned ST_FULL_BIT  = 1;
  localparam int unsigned ST_EMPTY_BIT = 2;
  localparam int unsigned ST_OVF_BIT   = 3;
  localparam int unsigned ST_COUNT_LSB = 8;
  localparam int unsigned ST_COUNT_W   = 4;

  // CTRL bit positions
  localparam int unsigned CTRL_EN_BIT = 0;

  localparam int unsigned DATA_BITS = 8;

  // Transmit FSM states; PARITY is only reachable in the parity build
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_t;

  // Even parity over one data byte
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// sync_fifo: single-clock FIFO with extra-MSB pointers for full/empty,
// combinational head output, occupancy count and asynchronous reset.
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the data-memory port.
// Registers: TXDATA (push), STATUS (busy/full/empty/ovf/count), CTRL (en).
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [9:0]  BASE_ADDR    = 10'h3F0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [9:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        hit,
  output logic        tx
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t state;
  tx_state_t state_next;

  logic [3:0]           offset;
  logic                 wr_txdata;
  logic                 wr_status;
  logic                 wr_ctrl;
  logic                 en;
  logic                 ovf;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        count;
  logic [7:0]           head;
  logic [7:0]           shift;
  logic [BW-1:0]        baud;
  logic [2:0]           bit_idx;
  logic                 bit_end;
  logic                 last_bit;
  logic [31:0]          status;
  logic                 unused_din;
`ifdef UART_TX_PARITY_EN
  logic                 par;
`endif

  assign unused_din = ^din[31:8];

  assign offset    = addr[3:0];
  assign hit       = (addr[9:4] == BASE_ADDR[9:4]);
  assign wr_txdata = we && hit && (offset == TXDATA_OFF);
  assign wr_status = we && hit && (offset == STATUS_OFF);
  assign wr_ctrl   = we && hit && (offset == CTRL_OFF);
  assign bit_end   = (baud == BAUD_LAST);
  assign last_bit  = (bit_idx == 3'(DATA_BITS - 1));

  // A push into a full FIFO is rejected inside the FIFO; ovf records it
  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_txdata),
    .pop   (pop),
    .din   (din[7:0]),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Control/status registers: enable and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en  <= 1'b1;
      ovf <= 1'b0;
    end else begin
      if (wr_ctrl) en <= din[CTRL_EN_BIT];
      if (wr_txdata && full) ovf <= 1'b1;
      else if (wr_status && din[ST_OVF_BIT]) ovf <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next state, line level and FIFO pop
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    tx         = 1'b1;
    unique case (state)
      S_IDLE: begin
        if (en && !empty) begin
          state_next = S_START;
          pop        = 1'b1;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (bit_end) state_next = S_DATA;
      end
      S_DATA: begin
        tx = shift[0];
        if (bit_end && last_bit) begin
`ifdef UART_TX_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx = par;
        if (bit_end) state_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (en && !empty) begin
            state_next = S_START;
            pop        = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Shift register, baud counter and bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift   <= '0;
      baud    <= '0;
      bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else if (pop) begin
      shift   <= head;
      baud    <= '0;
      bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
      par     <= even_parity(head);
`endif
    end else if (state != S_IDLE) begin
      baud <= bit_end ? '0 : baud + 1'b1;
      if (state == S_DATA && bit_end) begin
        shift   <= shift >> 1;
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // STATUS word assembly
  always_comb begin
    status                            = '0;
    status[ST_BUSY_BIT]               = (state != S_IDLE);
    status[ST_FULL_BIT]               = full;
    status[ST_EMPTY_BIT]              = empty;
    status[ST_OVF_BIT]                = ovf;
    status[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(count);
  end

  // Load-data mux; zero outside the window and at unmapped offsets
  always_comb begin
    dout = '0;
    if (hit) begin
      unique case (offset)
        STATUS_OFF: dout = status;
        CTRL_OFF:   dout = {31'd0, en};
        default:    dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stimulus queues expected frames, a
// line monitor decodes tx and compares against the queue.
module tb_mmio_uart_tx;

  localparam int unsigned C     = 4;
  localparam int unsigned DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif
  localparam int unsigned FRAME = NB * C;
  localparam logic [5:0]  WIN   = 6'h3F;

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         start;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [9:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        hit;
  logic        tx;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int          cyc    = 0;
  exp_t        sb[$];

  mmio_uart_tx #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (DEPTH),
    .BASE_ADDR    (10'h3F0)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (dout),
    .hit  (hit),
    .tx   (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [7:0] data, input logic par, input int start);
    exp_t e;
    e.data  = data;
    e.par   = par;
    e.start = start;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d, output int n);
    @(negedge clk);
    we   = 1'b1;
    addr = {WIN, off};
    din  = d;
    @(negedge clk);
    we = 1'b0;
    n  = cyc;
  endtask

  task automatic rd(input logic [3:0] off, output logic [31:0] d);
    @(negedge clk);
    addr = {WIN, off};
    #1 d = dout;
  endtask

  task automatic count_busy(input int unsigned span, output int unsigned busy);
    busy = 0;
    addr = {WIN, 4'h4};
    for (int unsigned i = 0; i < span; i++) begin
      #1 if (dout[0] === 1'b1) busy++;
      @(negedge clk);
    end
  endtask

  task automatic wait_drain(input int unsigned limit, input string name);
    int unsigned t;
    t = 0;
    while (sb.size() != 0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d frames outstanding, expected 0", name, sb.size());
    end
  endtask

  // Line monitor: decode each frame mid-bit and score it
  initial begin : monitor
    int         last_start;
    int         t0;
    logic [10:0] bits;
    logic       aborted;
    exp_t       e;
    int         es;
    last_start = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || tx !== 1'b0) continue;
      t0      = cyc;
      bits    = '0;
      aborted = 1'b0;
      for (int k = 0; k < int'(FRAME); k++) begin
        if (k > 0) @(negedge clk);
        if (rst !== 1'b0) aborted = 1'b1;
        if (k % C == C / 2) bits[k / C] = tx;
      end
      if (!aborted) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got frame starting cycle %0d, expected none", t0);
        end else begin
          e  = sb.pop_front();
          es = (e.start < 0) ? last_start + int'(FRAME) : e.start;
          chk("start_cycle", t0, es);
          chk("start_bit", {31'd0, bits[0]}, 32'd0);
          chk("data_bits", {24'd0, bits[8:1]}, {24'd0, e.data});
`ifdef UART_TX_PARITY_EN
          chk("parity_bit", {31'd0, bits[9]}, {31'd0, e.par});
`endif
          chk("stop_bit", {31'd0, bits[NB-1]}, 32'd1);
        end
        last_start = t0;
      end
    end
  end

  // Directed stimulus
  initial begin : stim
    int          n;
    logic [31:0] d;
    int unsigned lows;
    int unsigned busy;

    rst  = 1'b0;
    we   = 1'b0;
    addr = '0;
    din  = '0;
    #2 rst = 1'b1;
    #1 chk("tx_in_reset", {31'd0, tx}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle line after reset
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("idle_tx_low_cycles", lows, 0);
    rd(4'h4, d); chk("status_reset", d, 32'h004);
    rd(4'h8, d); chk("ctrl_reset", d, 32'h1);
    rd(4'h0, d); chk("txdata_read", d, 32'h0);
    rd(4'hC, d); chk("unmapped_read", d, 32'h0);
    @(negedge clk);
    addr = 10'h0F4;
    #1 chk("hit_outside", {31'd0, hit}, 32'd0);
    chk("dout_outside", dout, 32'h0);
    addr = {WIN, 4'h4};
    #1 chk("hit_inside", {31'd0, hit}, 32'd1);

    // Single frame 0xA5: starts one edge after the push, busy for one frame
    wr(4'h0, 32'hA5, n);
    expect_frame(8'hA5, 1'b0, n + 1);
    count_busy(FRAME + 20, busy);
    chk("busy_cycles_a5", busy, FRAME);

    // Back-to-back 0x55, 0x0F written on consecutive cycles
    @(negedge clk);
    we   = 1'b1;
    addr = {WIN, 4'h0};
    din  = 32'h55;
    @(negedge clk);
    din = 32'h0F;
    n   = cyc;
    expect_frame(8'h55, 1'b0, n + 1);
    expect_frame(8'h0F, 1'b0, -1);
    @(negedge clk);
    we   = 1'b0;
    addr = {WIN, 4'h4};
    #1 chk("count_after_b2b_push", {28'd0, dout[11:8]}, 32'd1);
    wait_drain(3 * FRAME, "drain_b2b");
    repeat (2) @(negedge clk);
    rd(4'h4, d); chk("status_after_b2b", d, 32'h004);

    // Disabled FIFO fill: ninth byte dropped, ovf sticky until cleared
    wr(4'h8, 32'h0, n);
    for (int i = 1; i <= 9; i++) wr(4'h0, i, n);
    rd(4'h4, d); chk("status_full_ovf", d, 32'h80A);
    rd(4'h8, d); chk("ctrl_disabled", d, 32'h0);
    wr(4'h4, 32'h8, n);
    rd(4'h4, d); chk("status_ovf_cleared", d, 32'h802);
    wr(4'h8, 32'h1, n);
    expect_frame(8'h01, 1'b1, n + 1);
    expect_frame(8'h02, 1'b1, -1);
    expect_frame(8'h03, 1'b0, -1);
    expect_frame(8'h04, 1'b1, -1);
    expect_frame(8'h05, 1'b0, -1);
    expect_frame(8'h06, 1'b0, -1);
    expect_frame(8'h07, 1'b1, -1);
    expect_frame(8'h08, 1'b1, -1);
    wait_drain(9 * FRAME + 20, "drain_fifo");
    repeat (2) @(negedge clk);
    rd(4'h4, d); chk("status_after_drain", d, 32'h004);

    // Reset in the middle of the data bits of 0x3C (bit1 is 0)
    wr(4'h0, 32'h3C, n);
    repeat (2 * C + 2) @(negedge clk);
    chk("tx_before_reset", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    #1 chk("tx_async_reset", {31'd0, tx}, 32'd1);
    addr = {WIN, 4'h4};
    #1 chk("status_during_reset", dout, 32'h004);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd(4'h4, d); chk("status_after_reset", d, 32'h004);
    rd(4'h8, d); chk("ctrl_after_reset", d, 32'h1);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("post_reset_tx_low_cycles", lows, 0);

    // 0x07: odd weight, parity bit 1 in the parity build
    wr(4'h0, 32'h07, n);
    expect_frame(8'h07, 1'b1, n + 1);
    count_busy(FRAME + 20, busy);
    chk("busy_cycles_07", busy, FRAME);
    wait_drain(FRAME + 20, "drain_07");
    rd(4'hC, d); chk("unmapped_read_end", d, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
